// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive deserialiser.
package uart_pkg;

    // Receive FSM states, in the order a frame walks through them.
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    // Parity sense: the XOR over data plus parity bit that a good frame yields.
    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

endpackage

// File: rtl/uart_rx_deser_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input.
// The reset value is a parameter so idle-high lines come out of reset idle.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Shift the raw input through two flops to settle metastability.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            // NOTE: non-blocking assignments keep both flops sampling the pre-edge values,
            // so the chain really is two stages deep regardless of statement order.
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uart_rx_deser.sv
// UART-style receive deserialiser: start-bit hunt on an oversampled line,
// mid-bit sampling, optional parity, 1 or 2 stop bits, and a valid/ready
// holding register with parity, framing and overrun reporting.
module uart_rx_deser #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 serialIn,
    input  logic                 sampleTick,
    output logic [DATA_BITS-1:0] parallelOut,
    output logic                 outValid,
    input  logic                 outReady,
    output logic                 parityErr,
    output logic                 frameErr,
    output logic                 overrun,
    output logic                 busy
);

    import uart_pkg::*;

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);

    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
    localparam logic          PAR_SENSE = (PARITY_ODD != 0) ? uart_pkg::PARITY_ODD
                                                            : uart_pkg::PARITY_EVEN;

    rx_state_t            r_state;
    rx_state_t            w_next_state;
    logic [TW-1:0]        r_tick_cnt;
    logic [TW-1:0]        w_tick_cnt;
    logic [BW-1:0]        r_bit_cnt;
    logic [BW-1:0]        w_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] w_shift;
    logic                 r_par_bad;
    logic                 w_par_bad;
    logic                 r_frame_bad;
    logic                 w_frame_bad;
    logic                 w_done;
    logic                 w_rx_s;

    logic [DATA_BITS-1:0] r_data;
    logic                 r_out_valid;
    logic                 r_parity_err;
    logic                 r_frame_err;
    logic                 r_overrun;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk   (clk),
        .rst_n (reset),
        .i_d   (serialIn),
        .o_q   (w_rx_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and next-datapath decode; everything holds unless a tick arrives.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can
        // leave one unassigned and infer a latch.
        w_next_state = r_state;
        w_tick_cnt   = r_tick_cnt;
        w_bit_cnt    = r_bit_cnt;
        w_shift      = r_shift;
        w_par_bad    = r_par_bad;
        w_frame_bad  = r_frame_bad;
        w_done       = 1'b0;

        if (sampleTick) begin
            case (r_state)
                IDLE: begin
                    if (!w_rx_s) begin
                        w_next_state = START;
                        w_tick_cnt   = '0;
                        w_par_bad    = 1'b0;
                        w_frame_bad  = 1'b0;
                    end
                end
                START: begin
                    if (r_tick_cnt == TICK_MID) begin
                        if (w_rx_s) begin
                            w_next_state = IDLE;      // glitch, not a start bit
                        end else begin
                            w_next_state = DATA;
                            w_tick_cnt   = '0;
                            w_bit_cnt    = '0;
                        end
                    end else begin
                        w_tick_cnt = r_tick_cnt + TW'(1);
                    end
                end
                DATA: begin
                    if (r_tick_cnt == TICK_LAST) begin
                        w_tick_cnt = '0;
                        w_shift    = {w_rx_s, r_shift[DATA_BITS-1:1]};
                        if (r_bit_cnt == BIT_LAST) begin
                            w_bit_cnt    = '0;
                            w_next_state = (PARITY_EN != 0) ? PARITY : STOP;
                        end else begin
                            w_bit_cnt = r_bit_cnt + BW'(1);
                        end
                    end else begin
                        w_tick_cnt = r_tick_cnt + TW'(1);
                    end
                end
                PARITY: begin
                    if (r_tick_cnt == TICK_LAST) begin
                        w_tick_cnt   = '0;
                        w_par_bad    = ((^{r_shift, w_rx_s}) != PAR_SENSE);
                        w_next_state = STOP;
                    end else begin
                        w_tick_cnt = r_tick_cnt + TW'(1);
                    end
                end
                STOP: begin
                    if (r_tick_cnt == TICK_LAST) begin
                        w_tick_cnt = '0;
                        if (!w_rx_s) begin
                            w_frame_bad = 1'b1;
                        end
                        if (r_bit_cnt == STOP_LAST) begin
                            w_bit_cnt    = '0;
                            w_next_state = IDLE;
                            w_done       = 1'b1;
                        end else begin
                            w_bit_cnt = r_bit_cnt + BW'(1);
                        end
                    end else begin
                        w_tick_cnt = r_tick_cnt + TW'(1);
                    end
                end
                default: begin
                    w_next_state = IDLE;
                end
            endcase
        end
    end

    // Counters, shift register and per-frame error accumulators.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tick_cnt  <= '0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_par_bad   <= 1'b0;
            r_frame_bad <= 1'b0;
        end else begin
            r_tick_cnt  <= w_tick_cnt;
            r_bit_cnt   <= w_bit_cnt;
            r_shift     <= w_shift;
            r_par_bad   <= w_par_bad;
            r_frame_bad <= w_frame_bad;
        end
    end

    // Holding register, handshake and the one-cycle error pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_data       <= '0;
            r_out_valid  <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_frame_err <= w_done & w_frame_bad;
            r_overrun   <= w_done & ~w_frame_bad & r_out_valid & ~outReady;
            if (w_done && !w_frame_bad && (!r_out_valid || outReady)) begin
                r_data       <= r_shift;
                r_parity_err <= r_par_bad;
                r_out_valid  <= 1'b1;
            end else if (r_out_valid && outReady) begin
                r_out_valid  <= 1'b0;
                r_parity_err <= 1'b0;
            end
        end
    end

    assign parallelOut = r_data;
    assign outValid    = r_out_valid;
    assign parityErr   = r_parity_err;
    assign frameErr    = r_frame_err;
    assign overrun     = r_overrun;
    assign busy        = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx_deser.sv
// Directed bench: instance A is 8N1, instance B is 8E1 (even parity).
// Tick every clock, 16 ticks per bit, so every bit is held for 16 clocks.
module tb_uart_rx_deser;

    logic clk      = 1'b0;
    logic rst_n    = 1'b0;
    logic line     = 1'b1;
    logic sel_b    = 1'b0;
    logic tick     = 1'b1;
    logic ready_a  = 1'b1;
    logic ready_b  = 1'b0;
    logic serial_a;
    logic serial_b;

    logic [7:0] data_a, data_b;
    logic       valid_a, perr_a, ferr_a, ovr_a, busy_a;
    logic       valid_b, perr_b, ferr_b, ovr_b, busy_b;

    int n_checks = 0;
    int n_fail   = 0;

    assign serial_a = sel_b ? 1'b1 : line;
    assign serial_b = sel_b ? line : 1'b1;

    always #5 clk = ~clk;

    uart_rx_deser u_dut_a (
        .clk         (clk),
        .reset       (rst_n),
        .serialIn    (serial_a),
        .sampleTick  (tick),
        .parallelOut (data_a),
        .outValid    (valid_a),
        .outReady    (ready_a),
        .parityErr   (perr_a),
        .frameErr    (ferr_a),
        .overrun     (ovr_a),
        .busy        (busy_a)
    );

    uart_rx_deser #(
        .PARITY_EN  (1),
        .PARITY_ODD (0)
    ) u_dut_b (
        .clk         (clk),
        .reset       (rst_n),
        .serialIn    (serial_b),
        .sampleTick  (tick),
        .parallelOut (data_b),
        .outValid    (valid_b),
        .outReady    (ready_b),
        .parityErr   (perr_b),
        .frameErr    (ferr_b),
        .overrun     (ovr_b),
        .busy        (busy_b)
    );

    // Monitor on A: deliveries, valid cycles and pulse counts, sampled after the falling edge.
    logic [8:0] dq_a[$];
    int   valid_cyc_a = 0;
    int   ferr_cnt_a  = 0;
    int   ferr_long_a = 0;
    int   ovr_cnt_a   = 0;
    int   ovr_long_a  = 0;
    logic ferr_prev   = 1'b0;
    logic ovr_prev    = 1'b0;

    always @(negedge clk) begin
        #1;
        if (valid_a) valid_cyc_a++;
        if (valid_a && ready_a) dq_a.push_back({perr_a, data_a});
        if (ferr_a) begin
            ferr_cnt_a++;
            if (ferr_prev) ferr_long_a++;
        end
        if (ovr_a) begin
            ovr_cnt_a++;
            if (ovr_prev) ovr_long_a++;
        end
        ferr_prev = ferr_a;
        ovr_prev  = ovr_a;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive pat[0] first, each bit for one bit period, then return the line to idle.
    task automatic send_bits(input logic [15:0] pat, input int n);
        for (int i = 0; i < n; i++) begin
            line = pat[i];
            repeat (16) @(negedge clk);
        end
        line = 1'b1;
    endtask

    function automatic logic [15:0] frame8(input logic [7:0] d, input logic stop);
        return {6'b111111, stop, d, 1'b0};
    endfunction

    function automatic logic [15:0] frame8p(input logic [7:0] d, input logic par, input logic stop);
        return {5'b11111, stop, par, d, 1'b0};
    endfunction

    int base_q, base_v, base_f, base_fl, base_o, base_ol;

    task automatic snap();
        base_q  = dq_a.size();
        base_v  = valid_cyc_a;
        base_f  = ferr_cnt_a;
        base_fl = ferr_long_a;
        base_o  = ovr_cnt_a;
        base_ol = ovr_long_a;
    endtask

    initial begin
        // Reset state
        repeat (4) @(negedge clk);
        check("rst_data_a",  32'(data_a),  32'h0);
        check("rst_valid_a", 32'(valid_a), 32'h0);
        check("rst_perr_a",  32'(perr_a),  32'h0);
        check("rst_ferr_a",  32'(ferr_a),  32'h0);
        check("rst_ovr_a",   32'(ovr_a),   32'h0);
        check("rst_busy_a",  32'(busy_a),  32'h0);
        check("rst_b_flags", 32'({valid_b, perr_b, ferr_b, ovr_b, busy_b}), 32'h0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // 1: 0xA5 8N1 with ready held high
        snap();
        send_bits(frame8(8'hA5, 1'b1), 10);
        repeat (20) @(negedge clk);
        check("t1_count", 32'(dq_a.size() - base_q), 32'd1);
        if (dq_a.size() > base_q) check("t1_char", 32'(dq_a[base_q]), 32'h0A5);
        check("t1_valid_cycles", 32'(valid_cyc_a - base_v), 32'd1);
        check("t1_ferr", 32'(ferr_cnt_a - base_f), 32'd0);
        check("t1_ovr",  32'(ovr_cnt_a - base_o),  32'd0);
        check("t1_busy", 32'(busy_a), 32'h0);

        // 2: three-tick glitch in idle is a false start
        snap();
        line = 1'b0;
        repeat (3) @(negedge clk);
        line = 1'b1;
        repeat (2) @(negedge clk);
        check("t2_busy_during", 32'(busy_a), 32'h1);
        repeat (30) @(negedge clk);
        check("t2_busy_after", 32'(busy_a), 32'h0);
        check("t2_no_char", 32'(dq_a.size() - base_q), 32'd0);
        check("t2_no_ferr", 32'(ferr_cnt_a - base_f), 32'd0);

        // 3: even parity, 0x07 with parity bit 0 -> parity error, held until ready
        sel_b = 1'b1;
        send_bits(frame8p(8'h07, 1'b0, 1'b1), 11);
        repeat (20) @(negedge clk);
        check("t3_valid", 32'(valid_b), 32'h1);
        check("t3_data",  32'(data_b),  32'h07);
        check("t3_perr",  32'(perr_b),  32'h1);
        check("t3_ferr",  32'(ferr_b),  32'h0);
        ready_b = 1'b1;
        @(negedge clk);
        ready_b = 1'b0;
        @(negedge clk);
        check("t3_valid_drop", 32'(valid_b), 32'h0);
        check("t3_perr_clear", 32'(perr_b),  32'h0);
        check("t3_data_hold",  32'(data_b),  32'h07);
        sel_b = 1'b0;
        repeat (4) @(negedge clk);

        // 4: 0x3C with stop bit 0 -> one-cycle frame error, nothing delivered
        snap();
        send_bits(frame8(8'h3C, 1'b0), 10);
        repeat (30) @(negedge clk);
        check("t4_ferr_pulses", 32'(ferr_cnt_a - base_f), 32'd1);
        check("t4_ferr_width",  32'(ferr_long_a - base_fl), 32'd0);
        check("t4_no_char",     32'(dq_a.size() - base_q), 32'd0);
        check("t4_valid",       32'(valid_a), 32'h0);

        // 5: ready low, 0x11 then 0x22 -> overrun on second, 0x11 kept
        snap();
        ready_a = 1'b0;
        send_bits(frame8(8'h11, 1'b1), 10);
        repeat (10) @(negedge clk);
        send_bits(frame8(8'h22, 1'b1), 10);
        repeat (20) @(negedge clk);
        check("t5_ovr_pulses", 32'(ovr_cnt_a - base_o), 32'd1);
        check("t5_ovr_width",  32'(ovr_long_a - base_ol), 32'd0);
        check("t5_held_valid", 32'(valid_a), 32'h1);
        check("t5_held_data",  32'(data_a),  32'h11);
        ready_a = 1'b1;
        repeat (5) @(negedge clk);
        check("t5_count", 32'(dq_a.size() - base_q), 32'd1);
        if (dq_a.size() > base_q) check("t5_char", 32'(dq_a[base_q]), 32'h011);
        check("t5_valid_after", 32'(valid_a), 32'h0);

        // 6: reset in the middle of 0xFF, then 0x5A is the only delivery
        snap();
        send_bits(frame8(8'hFF, 1'b1), 4);
        check("t6_busy_mid", 32'(busy_a), 32'h1);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("t6_rst_flags", 32'({valid_a, perr_a, ferr_a, ovr_a, busy_a}), 32'h0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("t6_flags_after", 32'({valid_a, perr_a, ferr_a, ovr_a, busy_a}), 32'h0);
        send_bits(frame8(8'h5A, 1'b1), 10);
        repeat (20) @(negedge clk);
        check("t6_count", 32'(dq_a.size() - base_q), 32'd1);
        if (dq_a.size() > base_q) check("t6_char", 32'(dq_a[base_q]), 32'h05A);
        check("t6_ferr", 32'(ferr_cnt_a - base_f), 32'd0);
        check("t6_ovr",  32'(ovr_cnt_a - base_o),  32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
        $finish;
    end

endmodule
